// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
// Optional feature macro used by this slice: IF_HALT_EN (stop issue after an all-ones word).
package if_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned CNT_W         = $clog2(DEFAULT_DEPTH) + 1;

    // Instruction word that halts fetch when IF_HALT_EN is defined.
    localparam logic [XLEN-1:0] HALT_WORD = '1;

    // Queue entry layout; the queue stores it flattened as {instr, pc_next}.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_next;
    } if_entry_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous prefetch FIFO with flush, push, pop, occupancy count and full/empty flags.
// Flush has priority over push and pop. DEPTH must be a power of two.
module if_fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer and occupancy state; flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: PC generation, credit-based issue to a synchronous instruction
// memory, prefetch queue with valid/ready handoff to decode, and branch redirect flush.
// Optional: define IF_HALT_EN to stop issue after an all-ones instruction is fetched.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     LEN      = XLEN,
    parameter int unsigned     ADDR_W   = 11,
    parameter int unsigned     DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [LEN-1:0]  RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LEN-1:0]    i_branch_dir,
    input  logic              i_PCSrc,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [LEN-1:0]    o_instruccion,
    output logic [LEN-1:0]    o_adder,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_en,
    input  logic [LEN-1:0]    i_imem_data
`ifdef IF_HALT_EN
    ,
    output logic              o_halted
`endif
);

    localparam int unsigned CntW = cnt_width(DEPTH);
    localparam int unsigned EntW = 2 * LEN;

    logic [LEN-1:0]  pc_q, pc_d;
    logic [LEN-1:0]  tag_q, tag_d;
    logic            inflight_q, inflight_d;
    logic            issue, push, pop, halt_block;
    logic [CntW-1:0] q_count;
    logic            q_full, q_empty;
    logic [EntW-1:0] q_rdata;
    logic [CntW:0]   occupancy;

    // Queued entries plus the read still in flight; a same-cycle pop adds no credit.
    assign occupancy = {1'b0, q_count} + {{CntW{1'b0}}, inflight_q};

`ifdef IF_HALT_EN
    logic halted_q, halted_d;
    logic halt_push;

    // Block issue in the very cycle the HALT word returns so nothing past it is fetched.
    assign halt_push  = push && (i_imem_data == {LEN{1'b1}});
    assign halt_block = halted_q || halt_push;
    assign o_halted   = halted_q;

    // Halt flag: set when HALT is pushed, cleared only by redirect or reset.
    always_comb begin
        halted_d = halted_q;
        if (i_PCSrc)        halted_d = 1'b0;
        else if (halt_push) halted_d = 1'b1;
    end

    // Halt flag register.
    always_ff @(posedge i_clk) begin
        if (i_rst) halted_q <= 1'b0;
        else       halted_q <= halted_d;
    end
`else
    assign halt_block = 1'b0;
`endif

    // A redirect kills the returning read and blocks issue, so the in-flight bit drops.
    assign push  = inflight_q && !i_PCSrc;
    assign pop   = !q_empty && i_ready && !i_PCSrc;
    assign issue = !i_rst && !i_PCSrc && !q_full && !halt_block
                   && (occupancy < (CntW+1)'(DEPTH));

    // Next PC, return tag and in-flight bit.
    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        if (i_PCSrc) begin
            pc_d = i_branch_dir;
        end else if (issue) begin
            pc_d  = pc_q + LEN'(PC_STEP);
            tag_d = pc_q + LEN'(PC_STEP);
        end
    end

    // PC, tag and in-flight registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    if_fetch_queue #(
        .WIDTH (EntW),
        .DEPTH (DEPTH),
        .CNT_W (CntW)
    ) u_queue (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (i_PCSrc),
        .push  (push),
        .wdata ({i_imem_data, tag_q}),
        .pop   (pop),
        .rdata (q_rdata),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign o_valid       = !q_empty;
    assign o_instruccion = o_valid ? q_rdata[EntW-1:LEN] : '0;
    assign o_adder       = o_valid ? q_rdata[LEN-1:0]    : '0;
    assign o_imem_en     = issue;
    assign o_imem_addr   = pc_q[ADDR_W-1:0];

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed self-checking bench for if_prefetch_unit: a word-addressed instance and a
// byte-stepped instance (PC_STEP=4, RESET_PC=0x400) share one memory image.
module tb_if_prefetch_unit;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcsrc = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] branch_dir = '0;

    logic        valid, en;
    logic [31:0] instr, adder, rdata;
    logic [10:0] addr;
    logic        valid2, en2;
    logic [31:0] instr2, adder2, rdata2;
    logic [10:0] addr2;
`ifdef IF_HALT_EN
    logic        halted, halted2;
`endif

    logic [31:0] mem [0:2047];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_en;

    always #5 clk = ~clk;

    if_prefetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_branch_dir  (branch_dir),
        .i_PCSrc       (pcsrc),
        .i_ready       (ready),
        .o_valid       (valid),
        .o_instruccion (instr),
        .o_adder       (adder),
        .o_imem_addr   (addr),
        .o_imem_en     (en),
        .i_imem_data   (rdata)
`ifdef IF_HALT_EN
        ,
        .o_halted      (halted)
`endif
    );

    if_prefetch_unit #(
        .PC_STEP  (4),
        .RESET_PC (32'h400)
    ) dut2 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_branch_dir  (32'h0),
        .i_PCSrc       (1'b0),
        .i_ready       (1'b1),
        .o_valid       (valid2),
        .o_instruccion (instr2),
        .o_adder       (adder2),
        .o_imem_addr   (addr2),
        .o_imem_en     (en2),
        .i_imem_data   (rdata2)
`ifdef IF_HALT_EN
        ,
        .o_halted      (halted2)
`endif
    );

    // Synchronous instruction memories: data one cycle after the enabled request.
    always @(posedge clk) if (en)  rdata  <= mem[addr];
    always @(posedge clk) if (en2) rdata2 <= mem[addr2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at +1 after the edge; outputs are sampled at +2.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Leaves the bench settled inside cycle 0 (first cycle with reset low).
    task automatic do_reset(input bit check_state);
        rst   = 1'b1;
        pcsrc = 1'b0;
        repeat (2) begin_cycle();
        settle();
        if (check_state) begin
            check("rst_valid", 32'(valid), 32'h0);
            check("rst_instr", instr, 32'h0);
            check("rst_adder", adder, 32'h0);
            check("rst_en", 32'(en), 32'h0);
        end
        begin_cycle();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        for (int k = 0; k < 2048; k++) mem[k] = 32'(k) + 32'h100;

        // Test 1: latency and back-to-back streaming; dut2 shows byte stepping.
        ready = 1'b1;
        do_reset(1'b1);
        check("t1_c0_en", 32'(en), 32'h1);
        check("t1_c0_addr", 32'(addr), 32'h0);
        check("t1_c0_valid", 32'(valid), 32'h0);
        check("t5_c0_addr", 32'(addr2), 32'h400);
        begin_cycle(); settle();
        check("t1_c1_valid", 32'(valid), 32'h0);
        check("t1_c1_addr", 32'(addr), 32'h1);
        check("t5_c1_addr", 32'(addr2), 32'h404);
        for (int c = 2; c < 8; c++) begin
            begin_cycle(); settle();
            check("t1_valid", 32'(valid), 32'h1);
            check("t1_instr", instr, 32'h100 + 32'(c - 2));
            check("t1_adder", adder, 32'(c - 1));
            if (c == 2) begin
                check("t5_c2_instr", instr2, 32'h500);
                check("t5_c2_adder", adder2, 32'h404);
            end
            if (c == 3) begin
                check("t5_c3_instr", instr2, 32'h504);
                check("t5_c3_adder", adder2, 32'h408);
            end
        end

        // Test 2: stall fills exactly DEPTH entries, then drains in order.
        ready = 1'b0;
        do_reset(1'b0);
        n_en = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                begin_cycle(); settle();
            end
            n_en += int'(en);
        end
        check("t2_issue_count", 32'(n_en), 32'd4);
        check("t2_en_stalled", 32'(en), 32'h0);
        check("t2_head_valid", 32'(valid), 32'h1);
        check("t2_head_instr", instr, 32'h100);
        begin_cycle();
        ready = 1'b1;
        settle();
        check("t2_c10_en", 32'(en), 32'h0);
        check("t2_c10_instr", instr, 32'h100);
        for (int c = 11; c < 16; c++) begin
            begin_cycle(); settle();
            check("t2_drain_instr", instr, 32'h100 + 32'(c - 10));
            if (c == 11) begin
                check("t2_c11_en", 32'(en), 32'h1);
                check("t2_c11_addr", 32'(addr), 32'h4);
            end
        end

        // Test 3: redirect in a steady stream.
        ready = 1'b1;
        do_reset(1'b0);
        repeat (6) begin
            begin_cycle(); settle();
        end
        pcsrc      = 1'b1;
        branch_dir = 32'h40;
        #1;
        check("t3_t_en", 32'(en), 32'h0);
        check("t3_t_head", instr, 32'h104);
        begin_cycle();
        pcsrc = 1'b0;
        settle();
        check("t3_t1_valid", 32'(valid), 32'h0);
        check("t3_t1_en", 32'(en), 32'h1);
        check("t3_t1_addr", 32'(addr), 32'h40);
        begin_cycle(); settle();
        check("t3_t2_valid", 32'(valid), 32'h0);
        check("t3_t2_addr", 32'(addr), 32'h41);
        begin_cycle(); settle();
        check("t3_t3_valid", 32'(valid), 32'h1);
        check("t3_t3_instr", instr, 32'h140);
        check("t3_t3_adder", adder, 32'h41);
        begin_cycle(); settle();
        check("t3_t4_instr", instr, 32'h141);
        check("t3_t4_adder", adder, 32'h42);

        // Test 4: back-to-back redirects, last one wins.
        do_reset(1'b0);
        repeat (5) begin
            begin_cycle(); settle();
        end
        pcsrc      = 1'b1;
        branch_dir = 32'h10;
        #1;
        check("t4_t_en", 32'(en), 32'h0);
        begin_cycle();
        branch_dir = 32'h20;
        settle();
        check("t4_t1_en", 32'(en), 32'h0);
        check("t4_t1_valid", 32'(valid), 32'h0);
        begin_cycle();
        pcsrc = 1'b0;
        settle();
        check("t4_t2_addr", 32'(addr), 32'h20);
        check("t4_t2_valid", 32'(valid), 32'h0);
        begin_cycle(); settle();
        check("t4_t3_valid", 32'(valid), 32'h0);
        begin_cycle(); settle();
        check("t4_t4_instr", instr, 32'h120);
        check("t4_t4_adder", adder, 32'h21);
        begin_cycle(); settle();
        check("t4_t5_instr", instr, 32'h121);

`ifdef IF_HALT_EN
        // Test 6: HALT word at address 3 stops issue until a redirect.
        mem[3] = HALT_WORD;
        do_reset(1'b0);
        repeat (4) begin
            begin_cycle(); settle();
        end
        check("t6_c4_en", 32'(en), 32'h0);
        begin_cycle(); settle();
        check("t6_c5_instr", instr, HALT_WORD);
        check("t6_c5_halted", 32'(halted), 32'h1);
        begin_cycle(); settle();
        check("t6_c6_valid", 32'(valid), 32'h0);
        check("t6_c6_en", 32'(en), 32'h0);
        pcsrc      = 1'b1;
        branch_dir = 32'h0;
        begin_cycle();
        pcsrc = 1'b0;
        settle();
        check("t6_c7_halted", 32'(halted), 32'h0);
        check("t6_c7_en", 32'(en), 32'h1);
        check("t6_c7_addr", 32'(addr), 32'h0);
        mem[3] = 32'h103;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Next-generation instruction fetch stage. Decouples PC generation from decode with a parametrised prefetch queue and a valid/ready handoff, and drives an external synchronous instruction memory. Handles branch redirect with full flush of the queue and of any in-flight read. Sits between the instruction RAM and the IF/ID boundary; replaces the single-register fetch latch.

Parameters:
LEN, 32, instruction and PC width
ADDR_W, 11, instruction memory address width (2048 words)
DEPTH, 4, prefetch queue entries (power of two, >=2)
PC_STEP, 1, PC increment per instruction (1 = word addressing, 4 = byte addressing)
RESET_PC, 0, PC value loaded on reset

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_branch_dir  in  LEN  redirect target
i_PCSrc  in  1  redirect/flush request, single-cycle pulse
i_ready  in  1  decode accepts head entry this cycle
o_valid  out  1  head entry valid
o_instruccion  out  LEN  head instruction; 0 when !o_valid
o_adder  out  LEN  head PC+PC_STEP; 0 when !o_valid
o_imem_addr  out  ADDR_W  read address, low ADDR_W bits of PC
o_imem_en  out  1  read request
i_imem_data  in  LEN  read data, valid exactly 1 cycle after o_imem_en

Behaviour:
- Reset (i_rst=1 at edge): PC<=RESET_PC; queue empty; in-flight cleared; o_valid=0, o_instruccion=0, o_adder=0, o_imem_en=0.
- Credit rule: issue when (occupancy + inflight) < DEPTH and no redirect this cycle. Queue can never overflow; a pop in the same cycle does not create a same-cycle credit.
- Issue: o_imem_en=1, o_imem_addr=PC; at edge PC<=PC+PC_STEP (mod 2^LEN); tag PC+PC_STEP held with in-flight bit.
- Return: cycle after issue, if in-flight and not killed, push {i_imem_data, tag} into queue.
- Pop: o_valid && i_ready at edge removes head. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Latency: first issue in the cycle after reset deasserts (cycle 0); push at end of cycle 1; o_valid=1 in cycle 2. Steady state sustains 1 instr/cycle with i_ready held high.
- Redirect (i_PCSrc=1 in cycle t): at edge t, queue cleared, in-flight killed (data returning in t+1 is dropped), PC<=i_branch_dir, no issue in t. o_valid=0 in t+1. Target issued in t+1 and visible in t+3. Redirect has priority over pop, push and issue. An i_ready in cycle t is ignored.
- Redirect while empty or while stalled (i_ready=0): same flush behaviour.
- Back-to-back redirects: the last one wins. Each redirect kills the outstanding read.
- i_ready=0 holds the head stable: outputs unchanged until popped or flushed.
- Reset mid-operation overrides redirect and all traffic.

Optional Feature:
IF_HALT_EN. When defined: a pushed instruction equal to all-ones (HALT) stops further issue after it. o_halted (1 bit, reset 0) rises when the HALT entry is pushed. The HALT entry is still delivered to decode. Only i_rst or a redirect clears o_halted and resumes issue. When undefined: no o_halted port, and all-ones is fetched like any other word.

Decomposition:
- Package if_pkg: HALT_WORD constant; queue entry struct {instr, pc_next}; localparam CNT_W = $clog2(DEPTH)+1.
- Sub-module if_fetch_queue: synchronous FIFO with flush, push, pop, count and full/empty flags. The top holds PC, credit, in-flight/kill logic and the halt logic.

Test Plan:
1. Reset, then i_ready=1, memory[k]=k+0x100 -> o_valid first high in cycle 2 with instr 0x100 and o_adder 1, then one instruction per cycle with no bubbles.
2. i_ready=0 for 10 cycles -> exactly DEPTH (4) entries fetched, o_imem_en low afterwards, head stays 0x100. Release -> in-order 0x100..0x103, then fetch resumes.
3. Steady stream, i_PCSrc=1 with i_branch_dir=0x40 in cycle t -> o_valid=0 in t+1 and t+2; cycle t+3 shows instr mem[0x40] with o_adder 0x41. The in-flight word is never delivered.
4. Redirects in cycles t and t+1 (targets 0x10, 0x20) -> only the 0x20 stream appears; nothing from 0x10.
5. With PC_STEP=4, RESET_PC=0x400 -> o_imem_addr sequence 0x400, 0x404, ... and o_adder equals PC+4.
6. IF_HALT_EN, mem[3]=0xFFFFFFFF -> 0xFFFFFFFF is delivered, o_halted=1, no issue beyond address 3. A redirect to 0 clears o_halted and fetch restarts.
